// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller.
// Optional break support is enabled by defining UART_TX_BREAK_EN.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    // Parity over a zero-extended payload; zero padding does not change the XOR.
    function automatic logic parity_bit(input logic [15:0] data, input logic par_typ);
        return (^data) ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Source-side handshake and frame configuration for uart_tx_frame_ctrl.
// send_break only exists when UART_TX_BREAK_EN is defined.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic                  data_ready;
`ifdef UART_TX_BREAK_EN
    logic                  send_break;

    modport master (output p_data, data_valid, par_en, par_typ, stop2, send_break,
                    input  data_ready);
    modport slave  (input  p_data, data_valid, par_en, par_typ, stop2, send_break,
                    output data_ready);
`else
    modport master (output p_data, data_valid, par_en, par_typ, stop2,
                    input  data_ready);
    modport slave  (input  p_data, data_valid, par_en, par_typ, stop2,
                    output data_ready);
`endif
endinterface

// File: rtl/uart_tx_serializer.sv
// LSB-first payload shift register with bit counter.
// The first ser_en after a load presents bit 0 without advancing the counter,
// so during data bit k the counter reads k and ser_done flags the last bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ser_en,
    output logic                  ser_data,
    output logic                  ser_done
);

    logic [DATA_WIDTH-1:0] shreg_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic                  first_r;

    // Load the payload on acceptance, then shift one bit per enabled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r <= {DATA_WIDTH{1'b0}};
            cnt_r   <= {CNT_WIDTH{1'b0}};
            first_r <= 1'b0;
        end else if (load) begin
            shreg_r <= load_data;
            cnt_r   <= {CNT_WIDTH{1'b0}};
            first_r <= 1'b1;
        end else if (ser_en) begin
            shreg_r <= {1'b0, shreg_r[DATA_WIDTH-1:1]};
            if (first_r) begin
                first_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
            first_r <= first_r;
        end
    end

    assign ser_data = shreg_r[0];
    assign ser_done = !first_r && (cnt_r == CNT_WIDTH'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start, DATA_WIDTH data bits (LSB first),
// optional parity, 1 or 2 stop bits, back-to-back frames without idle gap.
// Optional line break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_frame_ctrl_if.slave bus,
    output logic                tx_out,
    output logic                busy
);

    tx_state_e state_r;
    logic      tx_r;
    logic      busy_r;
    logic      par_en_r;
    logic      par_typ_r;
    logic      stop2_r;
    logic      par_data_r;
    logic      stop_last_r;

    logic      brk_s;
    logic      ready_s;
    logic      accept_s;
    logic      ser_en_s;
    logic      ser_data_s;
    logic      ser_done_s;

`ifdef UART_TX_BREAK_EN
    assign brk_s = bus.send_break;
`else
    assign brk_s = 1'b0;
`endif

    // Ready in IDLE (unless a break request wins) or during the final stop bit.
    always_comb begin
        ready_s = 1'b0;
        if (state_r == IDLE) begin
            ready_s = ~brk_s;
        end else if (state_r == STOP) begin
            ready_s = stop_last_r;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign accept_s       = bus.data_valid && ready_s;
    assign bus.data_ready = ready_s;
    assign ser_en_s       = (state_r == START) || ((state_r == DATA) && !ser_done_s);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .load_data (bus.p_data),
        .ser_en    (ser_en_s),
        .ser_data  (ser_data_s),
        .ser_done  (ser_done_s)
    );

    // Frame FSM; tx_r always holds the bit for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            tx_r        <= LINE_IDLE;
            busy_r      <= 1'b0;
            par_en_r    <= 1'b0;
            par_typ_r   <= PAR_EVEN;
            stop2_r     <= 1'b0;
            par_data_r  <= 1'b0;
            stop_last_r <= 1'b0;
        end else if (accept_s) begin
            state_r     <= START;
            tx_r        <= START_BIT;
            busy_r      <= 1'b1;
            par_en_r    <= bus.par_en;
            par_typ_r   <= bus.par_typ;
            stop2_r     <= bus.stop2;
            par_data_r  <= parity_bit(16'(bus.p_data), PAR_EVEN);
            stop_last_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (brk_s) begin
                        state_r <= BREAK;
                        tx_r    <= START_BIT;
                        busy_r  <= 1'b1;
                    end else begin
                        tx_r    <= LINE_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    state_r <= DATA;
                    tx_r    <= ser_data_s;
                end
                DATA: begin
                    if (!ser_done_s) begin
                        tx_r <= ser_data_s;
                    end else if (par_en_r) begin
                        state_r <= PARITY;
                        tx_r    <= par_data_r ^ par_typ_r;
                    end else begin
                        state_r     <= STOP;
                        tx_r        <= STOP_BIT;
                        stop_last_r <= ~stop2_r;
                    end
                end
                PARITY: begin
                    state_r     <= STOP;
                    tx_r        <= STOP_BIT;
                    stop_last_r <= ~stop2_r;
                end
                STOP: begin
                    if (!stop_last_r) begin
                        stop_last_r <= 1'b1;
                        tx_r        <= STOP_BIT;
                    end else begin
                        state_r <= IDLE;
                        tx_r    <= LINE_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    if (brk_s) begin
                        tx_r <= START_BIT;
                    end else begin
                        state_r     <= STOP;
                        tx_r        <= STOP_BIT;
                        stop_last_r <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_r     <= IDLE;
                    tx_r        <= LINE_IDLE;
                    busy_r      <= 1'b0;
                    stop_last_r <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out = tx_r;
    assign busy   = busy_r;

endmodule
